// File: rtl/aluout_pkg.sv
// aluout_pkg: shared widths, flag bit positions and entry layout for the ALU-out queue
package aluout_pkg;
  localparam int ALU_DATA_W = 8;
  localparam int ALU_FLAG_W = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic [ALU_FLAG_W-1:0] flags;
  } aluout_entry_t;
endpackage

// File: rtl/aluout_fifo_mem.sv
// aluout_fifo_mem: entry storage with synchronous write and combinational read
module aluout_fifo_mem #(
  parameter int W = 12,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [PW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [PW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/aluout_fifo.sv
// aluout_fifo: in-order queue of ALU results and flags with a registered head entry
module aluout_fifo
  import aluout_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int FLAG_W = ALU_FLAG_W,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic                         c22,
  input  logic [DATA_W-1:0]            alu_output,
  input  logic [FLAG_W-1:0]            alu_flags,
  input  logic                         pop,
  input  logic                         flush,
  output logic [DATA_W-1:0]            alu_out_register,
  output logic [FLAG_W-1:0]            alu_flags_out,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W = DATA_W + FLAG_W;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("aluout_fifo: DEPTH must be a power of two >= 2");
  end
  logic          push, pop_ok, push_ok;
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [W-1:0]  mem_q, head_nxt;
  assign push    = c22 & run;
  assign pop_ok  = pop & run & valid;
  assign push_ok = push & (~full | pop_ok);
  assign rd_nxt  = rd_ptr + PW'(pop_ok);
  assign cnt_nxt = count + CW'(push_ok) - CW'(pop_ok);
  // The head is registered, so an entry written this edge that becomes head is taken from the input
  assign head_nxt = cnt_nxt == '0 ? '0
                  : (push_ok && rd_nxt == wr_ptr) ? {alu_output, alu_flags} : mem_q;
  aluout_fifo_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .clock(clock),
    .we(push_ok & ~flush),
    .wa(wr_ptr),
    .wd({alu_output, alu_flags}),
    .ra(rd_nxt),
    .rd(mem_q)
  );
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      valid <= 1'b0;
      full <= 1'b0;
      overflow <= 1'b0;
      {alu_out_register, alu_flags_out} <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + PW'(push_ok);
      count <= cnt_nxt;
      valid <= cnt_nxt != '0;
      full <= cnt_nxt == CW'(DEPTH);
      overflow <= overflow | (push & full & ~pop_ok);
      {alu_out_register, alu_flags_out} <= head_nxt;
    end
  end
endmodule

// File: tb/tb_aluout_fifo.sv
// tb_aluout_fifo: directed checks of ordering, overflow, wrap, run gating, flush and reset
module tb_aluout_fifo;
  import aluout_pkg::*;
  logic       clock = 1'b0;
  logic       reset_n, run, c22, pop, flush;
  logic [7:0] alu_output;
  logic [3:0] alu_flags;
  logic [7:0] alu_out_register;
  logic [3:0] alu_flags_out;
  logic       valid, full, overflow;
  logic [2:0] count;
  int vectors = 0;
  int miscompares = 0;

  aluout_fifo #(.DATA_W(8), .FLAG_W(4), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .c22(c22),
    .alu_output(alu_output), .alu_flags(alu_flags), .pop(pop), .flush(flush),
    .alu_out_register(alu_out_register), .alu_flags_out(alu_flags_out),
    .valid(valid), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [7:0] d, input logic [3:0] f, input logic p);
    c22 = c;
    alu_output = d;
    alu_flags = f;
    pop = p;
  endtask

  initial begin
    logic [7:0] ed [4];
    logic [3:0] ef [4];
    ed = '{8'h22, 8'h33, 8'h44, 8'h66};
    ef = '{4'h2, 4'h4, 4'h8, 4'h6};
    reset_n = 1'b0; run = 1'b1; flush = 1'b0;
    drive(1'b1, 8'hAA, 4'hF, 1'b0);
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(alu_out_register), 0);
    chk("rst_flags", 32'(alu_flags_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_full", 32'(full), 0);
    reset_n = 1'b1;
    drive(1'b1, 8'h11, 4'(1 << FLAG_Z), 1'b0);
    tick();
    chk("first_valid", 32'(valid), 1);
    chk("first_data", 32'(alu_out_register), 32'h11);
    chk("first_flags", 32'(alu_flags_out), 1);
    chk("first_count", 32'(count), 1);
    drive(1'b1, 8'h22, 4'(1 << FLAG_N), 1'b0);
    tick();
    drive(1'b1, 8'h33, 4'(1 << FLAG_C), 1'b0);
    tick();
    drive(1'b1, 8'h44, 4'(1 << FLAG_V), 1'b0);
    tick();
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 4);
    chk("fill_head", 32'(alu_out_register), 32'h11);
    chk("fill_ovf", 32'(overflow), 0);
    drive(1'b1, 8'h55, 4'h5, 1'b0);
    tick();
    chk("ovf_count", 32'(count), 4);
    chk("ovf_head", 32'(alu_out_register), 32'h11);
    chk("ovf_flag", 32'(overflow), 1);
    drive(1'b1, 8'h66, 4'h6, 1'b1);
    tick();
    chk("pp_full_ovf", 32'(overflow), 1);
    chk("pp_full_count", 32'(count), 4);
    chk("pp_full_full", 32'(full), 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(alu_out_register), 32'(ed[i]));
      chk("drain_flags", 32'(alu_flags_out), 32'(ef[i]));
      chk("drain_count", 32'(count), 32'(4 - i));
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      tick();
    end
    chk("empty_valid", 32'(valid), 0);
    chk("empty_data", 32'(alu_out_register), 0);
    chk("empty_count", 32'(count), 0);
    tick();
    chk("pop_empty_count", 32'(count), 0);
    chk("pop_empty_valid", 32'(valid), 0);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 8'(i), 4'(i), 1'b0);
      tick();
      chk("wrap_data", 32'(alu_out_register), 32'(i));
      chk("wrap_count1", 32'(count), 1);
      drive(1'b0, 8'h00, 4'h0, 1'b1);
      tick();
      chk("wrap_count0", 32'(count), 0);
      chk("wrap_valid0", 32'(valid), 0);
    end
    drive(1'b1, 8'h5A, 4'h3, 1'b0);
    tick();
    drive(1'b1, 8'hA5, 4'hC, 1'b1);
    tick();
    chk("bypass_data", 32'(alu_out_register), 32'hA5);
    chk("bypass_flags", 32'(alu_flags_out), 32'hC);
    chk("bypass_count", 32'(count), 1);
    drive(1'b1, 8'hB1, 4'h1, 1'b1);
    tick();
    chk("b1_head", 32'(alu_out_register), 32'hB1);
    drive(1'b1, 8'hB2, 4'h2, 1'b0);
    tick();
    chk("gate_pre_count", 32'(count), 2);
    run = 1'b0;
    drive(1'b1, 8'hCC, 4'hC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate_count", 32'(count), 2);
      chk("gate_head", 32'(alu_out_register), 32'hB1);
    end
    run = 1'b1;
    drive(1'b1, 8'hC3, 4'h3, 1'b0);
    tick();
    chk("three_count", 32'(count), 3);
    chk("three_ovf", 32'(overflow), 1);
    flush = 1'b1;
    drive(1'b1, 8'h77, 4'h7, 1'b1);
    tick();
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(valid), 0);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_data", 32'(alu_out_register), 0);
    flush = 1'b0;
    drive(1'b1, 8'h88, 4'h8, 1'b0);
    tick();
    chk("post_flush_data", 32'(alu_out_register), 32'h88);
    chk("post_flush_count", 32'(count), 1);
    reset_n = 1'b0;
    drive(1'b1, 8'h99, 4'h9, 1'b0);
    tick();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_data", 32'(alu_out_register), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aluout_fifo.md
# aluout_fifo

Parametrised successor to the single ALU-out register in the multicycle datapath. Captures ALU result plus status flags whenever the capture enable is asserted during run, and holds up to DEPTH entries in order, so execute can run ahead of a stalled writeback/memory stage. Sits between the ALU and the writeback mux. The head entry is always presented on registered outputs.

## Interface
Parameters:
- DATA_W, 8, ALU result width
- FLAG_W, 4, status flag width (bit order from shared package: Z, N, C, V)
- DEPTH, 4, entry count; power of two, ≥ 2

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clock
- run  in  1  global run gate; when low, no push, no pop, state frozen (flush and reset still act)
- c22  in  1  capture enable (push request)
- alu_output  in  DATA_W  ALU result to capture
- alu_flags  in  FLAG_W  ALU flags to capture with the result
- pop  in  1  consumer accepts head entry
- flush  in  1  discard all entries (pipeline squash)
- alu_out_register  out  DATA_W  head entry data
- alu_flags_out  out  FLAG_W  head entry flags
- valid  out  1  head entry present (not empty)
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH+1)  entries held
- overflow  out  1  sticky: capture attempted while full with no pop

## Operation
- push = c22 & run; pop_ok = pop & run & valid.
- Priority per cycle: reset_n low > flush > push/pop.
- Reset (reset_n low at edge): pointers, count, overflow cleared; alu_out_register = 0, alu_flags_out = 0, valid = 0, full = 0, count = 0.
- Flush: count, pointers → 0; valid = 0; head outputs → 0; overflow cleared; concurrent push and pop ignored.
- Push when not full: write {alu_output, alu_flags} at write pointer, advance pointer (mod DEPTH).
- Push when full and no pop_ok: data dropped, state unchanged, overflow set to 1.
- Push when full with pop_ok: both accepted; count stays DEPTH; no overflow.
- Push when empty with pop: pop ignored (valid was 0); entry becomes head.
- Pop on valid: advance read pointer, count − 1; pop on empty ignored, no error.
- Head outputs show entry at read pointer whenever valid; forced to 0 when empty.
- Pointers log2(DEPTH) bits, wrap naturally; count is exact, no pointer-compare for full/empty.
- run low: push and pop ignored even if c22/pop high; outputs hold.

## Timing
- All outputs registered; change only after rising edge.
- Push into empty at edge N → valid = 1 and data on alu_out_register after edge N (one-cycle latency, no bypass).
- Pop at edge N → next entry (or empty) visible after edge N.
- full/count/valid/overflow update same edge as the push/pop causing them.
- Throughput: one push and one pop per cycle sustained.
- Reset or flush mid-stream takes effect at that edge; stored data no longer observable.

## Structure
- Shared package aluout_pkg: DATA_W/FLAG_W defaults, flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3, entry struct {data, flags}.
- One sub-module: aluout_fifo_mem — DEPTH × (DATA_W+FLAG_W) storage, synchronous write, combinational read at read pointer; pointer/count/overflow logic stays in aluout_fifo.
- DEPTH validated at elaboration (power of two, ≥ 2).

## Test plan
- Reset: drive reset_n = 0 one edge with c22 = 1, run = 1, alu_output = 8'hAA → count 0, valid 0, alu_out_register 8'h00, overflow 0.
- Fill/drain order: push 8'h11, 22, 33, 44 (flags 1,2,4,8) → full = 1, count 4; pop ×4 → heads 11/1, 22/2, 33/4, 44/8 in order, then valid 0.
- Overflow: on full queue push 8'h55 without pop → count 4, head still 8'h11, overflow 1; push 8'h66 with pop same cycle → overflow unchanged, count 4, 8'h66 last out.
- Wrap-around: 10 alternating push/pop cycles with values 0x01..0x0A → each value emerges one cycle after push, count toggles 1/0, pointers wrap with no loss.
- Run gating: with 2 entries, run = 0, c22 = 1, pop = 1 for 3 cycles → count stays 2, head unchanged.
- Flush vs push: 3 entries, flush = 1 with c22 = 1 (8'h77) and pop = 1 → count 0, valid 0, overflow 0; next cycle push 8'h88 → head 8'h88.
